// File: rtl/adder_pkg.sv
// Shared adder definitions: opcode encodings and the
// generic ripple carry chain used by every adder variant.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int CC_MAXW = 64;

  // Returns {cout, carry into bit w-1, sum}; bits at and above w read zero.
  function automatic logic [CC_MAXW+1:0] carry_chain(
    input logic [CC_MAXW-1:0] a,
    input logic [CC_MAXW-1:0] b,
    input logic               cin,
    input int                 w
  );
    logic [CC_MAXW-1:0] s;
    logic               c;
    logic               cm;
    s  = '0;
    c  = cin;
    cm = cin;
    for (int i = 0; i < CC_MAXW; i++) begin
      if (i < w) begin
        cm   = c;
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    return {c, cm, s};
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational W-bit ripple segment; one per pipeline stage.
// Also exposes the carry into its top bit for overflow detection.
module rca_segment #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);
  import adder_pkg::*;

  if (W < 1 || W > CC_MAXW) begin : g_bad_w
    $error("rca_segment: W out of range");
  end

  logic [CC_MAXW-1:0] a_ext;
  logic [CC_MAXW-1:0] b_ext;
  logic [CC_MAXW+1:0] r;

  always_comb begin
    a_ext        = '0;
    b_ext        = '0;
    a_ext[W-1:0] = a;
    b_ext[W-1:0] = b;
    r            = carry_chain(a_ext, b_ext, cin, W);
  end

  assign sum      = r[W-1:0];
  assign cout     = r[CC_MAXW+1];
  assign c_msb_in = r[CC_MAXW];

  if (W < CC_MAXW) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^r[CC_MAXW-1:W];
  end

endmodule

// File: rtl/rca_pipelined_addsub.sv
// Pipelined ripple-carry add/subtract, one carry segment per stage.
// Single global enable: the whole pipe advances or holds together.
module rca_pipelined_addsub #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic [N:0]   final_sum
);
  import adder_pkg::*;

  localparam int SEG = N / STAGES;

  if (STAGES < 1 || STAGES > N) begin : g_bad_stages
    $error("rca_pipelined_addsub: STAGES out of range");
  end
  if (N % STAGES != 0) begin : g_bad_split
    $error("rca_pipelined_addsub: N not divisible by STAGES");
  end

  logic                      adv;
  logic [STAGES-1:0]         v_q, v_d;
  logic [STAGES-1:0]         c_q, c_d;
  logic [STAGES-1:0][N-1:0]  a_q, a_d;
  logic [STAGES-1:0][N-1:0]  b_q, b_d;
  logic [STAGES-1:0][N-1:0]  s_q, s_d;
  logic                      cm_q, cm_d;

  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic         v_in;
    logic         c_in;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [N-1:0] s_in;
    logic [N-1:0] s_nx;
    logic [SEG-1:0] seg_sum;
    logic         seg_c;
    logic         seg_cm;

    if (s == 0) begin : g_head
      assign v_in = in_valid;
      assign a_in = a;
      assign b_in = b ^ {N{op}};
      assign s_in = '0;
      assign c_in = (op == OP_SUB) ? 1'b1 : cin;
    end else begin : g_body
      assign v_in = v_q[s-1];
      assign a_in = a_q[s-1];
      assign b_in = b_q[s-1];
      assign s_in = s_q[s-1];
      assign c_in = c_q[s-1];
    end

    rca_segment #(.W(SEG)) u_seg (
      .a        (a_in[s*SEG +: SEG]),
      .b        (b_in[s*SEG +: SEG]),
      .cin      (c_in),
      .sum      (seg_sum),
      .cout     (seg_c),
      .c_msb_in (seg_cm)
    );

    always_comb begin
      s_nx                = s_in;
      s_nx[s*SEG +: SEG]  = seg_sum;
    end

    assign v_d[s] = v_in;
    assign a_d[s] = a_in;
    assign b_d[s] = b_in;
    assign s_d[s] = s_nx;
    assign c_d[s] = seg_c;

    if (s == STAGES - 1) begin : g_tail
      assign cm_d = seg_cm;
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = seg_cm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      c_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      cm_q <= 1'b0;
    end else if (adv) begin
      v_q  <= v_d;
      c_q  <= c_d;
      a_q  <= a_d;
      b_q  <= b_d;
      s_q  <= s_d;
      cm_q <= cm_d;
    end
  end

  // Operands have been fully consumed by the time they reach the last stage.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = c_q[STAGES-1] ^ cm_q;
  assign final_sum = {cout, sum};

endmodule

// File: tb/tb_rca_pipelined_addsub.sv
// Bench for rca_pipelined_addsub: N=4/STAGES=2 and N=32/STAGES=4
// instances, checked against an arithmetic reference model.
module tb_rca_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        d4_in_valid, d4_in_ready, d4_cin, d4_op;
  logic        d4_out_valid, d4_out_ready, d4_cout, d4_ovf;
  logic [3:0]  d4_a, d4_b, d4_sum;
  logic [4:0]  d4_final;

  logic        d32_in_valid, d32_in_ready, d32_cin, d32_op;
  logic        d32_out_valid, d32_out_ready, d32_cout, d32_ovf;
  logic [31:0] d32_a, d32_b, d32_sum;
  logic [32:0] d32_final;

  rca_pipelined_addsub #(.N(4), .STAGES(2)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .a(d4_a), .b(d4_b), .cin(d4_cin), .op(d4_op),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready),
    .sum(d4_sum), .cout(d4_cout), .ovf(d4_ovf),
    .final_sum(d4_final)
  );

  rca_pipelined_addsub #(.N(32), .STAGES(4)) u_d32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d32_in_valid), .in_ready(d32_in_ready),
    .a(d32_a), .b(d32_b), .cin(d32_cin), .op(d32_op),
    .out_valid(d32_out_valid), .out_ready(d32_out_ready),
    .sum(d32_sum), .cout(d32_cout), .ovf(d32_ovf),
    .final_sum(d32_final)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } res_t;

  // Plain integer arithmetic: unsigned result/carry and signed-range overflow.
  function automatic res_t model(input int n, input longint a,
                                 input longint b, input bit cin,
                                 input bit op);
    longint m, sa, sb, t, r;
    res_t   o;
    m  = longint'(1) << n;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (!op) begin
      t   = a + b + longint'(cin);
      o.c = (t >= m);
      o.s = 32'(t % m);
      r   = sa + sb + longint'(cin);
    end else begin
      t   = a - b;
      o.c = (a >= b);
      o.s = 32'((t + m) % m);
      r   = sa - sb;
    end
    o.v = (r >= m / 2) || (r < -(m / 2));
    return o;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic n4_beat(input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic op,
                         output logic early_v, output logic v,
                         output logic [3:0] s, output logic c,
                         output logic o, output logic [4:0] f);
    d4_a = a; d4_b = b; d4_cin = cin; d4_op = op;
    d4_in_valid = 1'b1; d4_out_ready = 1'b1;
    step();
    d4_in_valid = 1'b0;
    early_v = d4_out_valid;
    step();
    v = d4_out_valid; s = d4_sum; c = d4_cout; o = d4_ovf; f = d4_final;
    step();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (d32_out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", d32_out_valid);
    end
    checks++;
    if (d32_final !== 33'd0 || d32_sum !== 32'd0) begin
      failures++; $display("FAIL reset_sum got=%h exp=0", d32_final);
    end
    checks++;
    if (d32_cout !== 1'b0 || d32_ovf !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b exp=00", d32_cout, d32_ovf);
    end
    checks++;
    if (d32_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", d32_in_ready);
    end
    checks++;
    if (d4_out_valid !== 1'b0 || d4_final !== 5'd0) begin
      failures++; $display("FAIL reset_d4 got=%b/%h exp=0/0", d4_out_valid, d4_final);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_n4;
    logic ev, v, c, o; logic [3:0] s; logic [4:0] f; res_t e;
    e = model(4, 5, 9, 1'b0, 1'b0);
    n4_beat(4'd5, 4'd9, 1'b0, 1'b0, ev, v, s, c, o, f);
    checks++;
    if (ev !== 1'b0 || v !== 1'b1) begin
      failures++; $display("FAIL n4_add_latency got=%b%b exp=01", ev, v);
    end
    checks++;
    if ({f, s, c, o} !== {e.c, e.s[3:0], e.s[3:0], e.c, e.v}) begin
      failures++;
      $display("FAIL n4_add got=%h/%h/%b/%b exp=%h/%b/%b", f, s, c, o, e.s[3:0], e.c, e.v);
    end
  endtask

  task automatic test_sub_n4;
    logic ev, v, c, o; logic [3:0] s; logic [4:0] f; res_t e;
    logic [3:0] av [2];
    logic [3:0] bv [2];
    av[0] = 4'd3; bv[0] = 4'd5;
    av[1] = 4'd8; bv[1] = 4'd1;
    for (int i = 0; i < 2; i++) begin
      e = model(4, longint'(av[i]), longint'(bv[i]), 1'b1, 1'b1);
      n4_beat(av[i], bv[i], 1'b1, 1'b1, ev, v, s, c, o, f);
      checks++;
      if (v !== 1'b1 || {f, s, c, o} !== {e.c, e.s[3:0], e.s[3:0], e.c, e.v}) begin
        failures++;
        $display("FAIL n4_sub%0d got=%b/%h/%b/%b exp=%h/%b/%b", i, v, s, c, o, e.s[3:0], e.c, e.v);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic        cv [3];
    res_t        e;
    int          got;
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'd1; cv[0] = 1'b0;
    av[1] = 32'd0;         bv[1] = 32'd0; cv[1] = 1'b1;
    av[2] = 32'h7FFF_FFFF; bv[2] = 32'd1; cv[2] = 1'b0;
    got = 0;
    d32_out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        d32_in_valid = 1'b1; d32_op = 1'b0;
        d32_a = av[c]; d32_b = bv[c]; d32_cin = cv[c];
      end else begin
        d32_in_valid = 1'b0;
      end
      @(negedge clk);
      if (d32_out_valid) begin
        checks++;
        if (got >= 3) begin
          failures++; $display("FAIL b2b_extra cycle=%0d", c);
        end else begin
          e = model(32, longint'(av[got]), longint'(bv[got]), cv[got], 1'b0);
          if (c !== got + 4 || d32_sum !== e.s || d32_cout !== e.c || d32_ovf !== e.v) begin
            failures++;
            $display("FAIL b2b_beat%0d got=cyc%0d %h/%b/%b exp=cyc%0d %h/%b/%b",
                     got, c, d32_sum, d32_cout, d32_ovf, got + 4, e.s, e.c, e.v);
          end
        end
        got++;
      end
      step();
    end
    checks++;
    if (got !== 3) begin
      failures++; $display("FAIL b2b_count got=%0d exp=3", got);
    end
  endtask

  task automatic test_backpressure;
    res_t q[$];
    res_t e;
    int   got;
    d32_out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      d32_in_valid = 1'b1;
      d32_a = $urandom; d32_b = $urandom;
      d32_cin = 1'($urandom); d32_op = 1'($urandom);
      @(negedge clk);
      checks++;
      if (d32_in_ready !== 1'b1) begin
        failures++; $display("FAIL bp_fill_ready cycle=%0d got=%b exp=1", c, d32_in_ready);
      end
      q.push_back(model(32, longint'(d32_a), longint'(d32_b), d32_cin, d32_op));
      step();
    end
    // Offer a beat during the stall; it must not be taken.
    d32_a = $urandom; d32_b = $urandom;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (d32_out_valid !== 1'b1 || d32_in_ready !== 1'b0 || d32_sum !== q[0].s) begin
        failures++;
        $display("FAIL bp_stall k=%0d got=%b/%b/%h exp=1/0/%h",
                 k, d32_out_valid, d32_in_ready, d32_sum, q[0].s);
      end
      step();
    end
    d32_in_valid  = 1'b0;
    d32_out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d32_out_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL bp_extra cycle=%0d sum=%h", c, d32_sum);
        end else begin
          e = q.pop_front();
          if (d32_sum !== e.s || d32_cout !== e.c || d32_ovf !== e.v) begin
            failures++;
            $display("FAIL bp_drain%0d got=%h/%b/%b exp=%h/%b/%b",
                     got, d32_sum, d32_cout, d32_ovf, e.s, e.c, e.v);
          end
        end
        got++;
      end
      step();
    end
    checks++;
    if (got !== 4) begin
      failures++; $display("FAIL bp_count got=%0d exp=4", got);
    end
  endtask

  task automatic test_reset_mid;
    res_t e;
    int   n;
    d32_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      d32_in_valid = (c < 3);
      d32_op = 1'b0; d32_cin = 1'b0;
      d32_a = 32'h1000_0000 + 32'(c); d32_b = 32'h0000_0011;
      step();
    end
    d32_in_valid = 1'b0;
    checks++;
    if (d32_out_valid !== 1'b1 || d32_sum !== 32'h1000_0011) begin
      failures++; $display("FAIL rmid_pre got=%b/%h exp=1/10000011", d32_out_valid, d32_sum);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (d32_out_valid !== 1'b0 || d32_sum !== 32'd0 || d32_cout !== 1'b0) begin
      failures++; $display("FAIL rmid_clear got=%b/%h/%b exp=0/0/0", d32_out_valid, d32_sum, d32_cout);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    n = 0;
    e = model(32, 64'h0000_1234, 64'h0000_0100, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      d32_in_valid = (c == 0);
      d32_op = 1'b1; d32_cin = 1'b0;
      d32_a = 32'h0000_1234; d32_b = 32'h0000_0100;
      @(negedge clk);
      if (d32_out_valid) begin
        n++;
        checks++;
        if (c !== 4 || d32_sum !== e.s || d32_cout !== e.c) begin
          failures++;
          $display("FAIL rmid_beat got=cyc%0d %h/%b exp=cyc4 %h/%b", c, d32_sum, d32_cout, e.s, e.c);
        end
      end
      step();
    end
    d32_in_valid = 1'b0;
    checks++;
    if (n !== 1) begin
      failures++; $display("FAIL rmid_count got=%0d exp=1", n);
    end
  endtask

  task automatic test_random;
    res_t        q[$];
    res_t        e;
    int          sent, recv, cyc;
    logic        prev_stall;
    logic [32:0] prev_final;
    sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0; prev_final = '0;
    while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
      d32_in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
      d32_out_ready = ($urandom_range(0, 9) < 7);
      d32_a   = $urandom;
      d32_b   = $urandom;
      d32_cin = 1'($urandom);
      d32_op  = 1'($urandom);
      if ($urandom_range(0, 15) == 0) d32_b = d32_a;
      if ($urandom_range(0, 15) == 0) d32_a = 32'h8000_0000;
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (d32_out_valid !== 1'b1 || d32_final !== prev_final) begin
          failures++;
          $display("FAIL rnd_stall cyc=%0d got=%b/%h exp=1/%h", cyc, d32_out_valid, d32_final, prev_final);
        end
      end
      if (d32_out_valid && d32_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rnd_extra cyc=%0d sum=%h", cyc, d32_sum);
        end else begin
          e = q.pop_front();
          if (d32_final !== {e.c, e.s} || d32_ovf !== e.v) begin
            failures++;
            $display("FAIL rnd_beat%0d got=%h/%b exp=%h/%b", recv, d32_final, d32_ovf, {e.c, e.s}, e.v);
          end
        end
        recv++;
      end
      if (d32_in_valid && d32_in_ready) begin
        q.push_back(model(32, longint'(d32_a), longint'(d32_b), d32_cin, d32_op));
        sent++;
      end
      prev_stall = d32_out_valid && !d32_out_ready;
      prev_final = d32_final;
      cyc++;
      step();
    end
    d32_in_valid  = 1'b0;
    d32_out_ready = 1'b1;
    checks++;
    if (sent !== 10000 || q.size() !== 0) begin
      failures++; $display("FAIL rnd_timeout sent=%0d pending=%0d exp=10000/0", sent, q.size());
    end
  endtask

  initial begin
    d4_in_valid = 1'b0; d4_out_ready = 1'b1;
    d4_a = '0; d4_b = '0; d4_cin = 1'b0; d4_op = 1'b0;
    d32_in_valid = 1'b0; d32_out_ready = 1'b1;
    d32_a = '0; d32_b = '0; d32_cin = 1'b0; d32_op = 1'b0;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_add_n4();
    test_sub_n4();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
